// File: rtl/alu_operand_stage.sv
// Operand and flag stage around the 8-bit adder: A/B operand registers
// loaded from the shared bus, add/subtract through one adder, a result
// bus driver and carry/zero flags for the sequencer's conditional jumps.
module alu_operand_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             ai,
    input  logic             bi,
    input  logic             su,
    input  logic             ac,
    input  logic             eo,
    input  logic             ao,
    input  logic             fi,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    output logic             bus_conflict,
    output logic [WIDTH-1:0] a_val,
    output logic [WIDTH-1:0] b_val,
    output logic             carry_flag,
    output logic             zero_flag
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cf_q, cf_d;
    logic             zf_q, zf_d;

    logic [WIDTH-1:0] operand2;
    logic             carry_in;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Adder: subtract is A + ~B + 1, so cout=1 means no borrow (A >= B).
    always_comb begin
        operand2 = su ? ~b_q : b_q;
        carry_in = su ? 1'b1 : (ac & cf_q);
        add_full = {1'b0, a_q} + {1'b0, operand2} + {{WIDTH{1'b0}}, carry_in};
        sum      = add_full[WIDTH-1:0];
        cout     = add_full[WIDTH];
    end

    // Bus driver: result has priority over A when both are requested.
    always_comb begin
        bus_oe       = eo | ao;
        bus_conflict = eo & ao;
        if (eo) begin
            bus_out = sum;
        end else if (ao) begin
            bus_out = a_q;
        end else begin
            bus_out = '0;
        end
    end

    // Next-state: flags sample the pre-edge adder, so a same-cycle load
    // of A/B only affects the result from the following cycle.
    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        cf_d = cf_q;
        zf_d = zf_q;
        if (ai) begin
            a_d = bus_in;
        end
        if (bi) begin
            b_d = bus_in;
        end
        if (fi) begin
            cf_d = cout;
            zf_d = (sum == '0);
        end
    end

    // State registers with synchronous clear overriding every strobe.
    always_ff @(posedge clk) begin
        if (clr) begin
            a_q  <= '0;
            b_q  <= '0;
            cf_q <= 1'b0;
            zf_q <= 1'b0;
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            cf_q <= cf_d;
            zf_q <= zf_d;
        end
    end

    assign a_val      = a_q;
    assign b_val      = b_q;
    assign carry_flag = cf_q;
    assign zero_flag  = zf_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed sequences with literal expectations,
// then randomized strobes, all compared every cycle against a bench model.
module tb_alu_operand_stage;

    logic       clk = 1'b0;
    logic       clr, ai, bi, su, ac, eo, ao, fi;
    logic [7:0] bus_in;
    logic [7:0] bus_out, a_val, b_val;
    logic       bus_oe, bus_conflict, carry_flag, zero_flag;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Model state as plain integers.
    int m_a = 0, m_b = 0, m_cf = 0, m_zf = 0;

    alu_operand_stage #(.WIDTH(8)) dut (
        .clk(clk), .clr(clr), .bus_in(bus_in),
        .ai(ai), .bi(bi), .su(su), .ac(ac), .eo(eo), .ao(ao), .fi(fi),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_conflict(bus_conflict),
        .a_val(a_val), .b_val(b_val),
        .carry_flag(carry_flag), .zero_flag(zero_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare DUT against the model, then advance the model to the next edge.
    always @(negedge clk) begin
        if (check_en) begin
            int res, s, co, eb;
            if (su) begin
                res = m_a - m_b;
                co  = (m_a >= m_b) ? 1 : 0;
            end else begin
                res = m_a + m_b + ((ac && m_cf != 0) ? 1 : 0);
                co  = (res > 255) ? 1 : 0;
            end
            s  = res & 255;
            eb = eo ? s : (ao ? m_a : 0);
            chk("bus_out", {24'd0, bus_out}, eb);
            chk("bus_oe", {31'd0, bus_oe}, (eo || ao) ? 1 : 0);
            chk("bus_conflict", {31'd0, bus_conflict}, (eo && ao) ? 1 : 0);
            chk("a_val", {24'd0, a_val}, m_a);
            chk("b_val", {24'd0, b_val}, m_b);
            chk("carry_flag", {31'd0, carry_flag}, m_cf);
            chk("zero_flag", {31'd0, zero_flag}, m_zf);
            if (clr) begin
                m_a = 0; m_b = 0; m_cf = 0; m_zf = 0;
            end else begin
                if (fi) begin
                    m_cf = co;
                    m_zf = (s == 0) ? 1 : 0;
                end
                if (ai) m_a = int'(bus_in);
                if (bi) m_b = int'(bus_in);
            end
        end
    end

    task automatic drive(input logic [7:0] v, input logic c, input logic a_, input logic b_,
                         input logic s_, input logic ac_, input logic e_, input logic ao_,
                         input logic f_);
        bus_in = v; clr = c; ai = a_; bi = b_; su = s_; ac = ac_; eo = e_; ao = ao_; fi = f_;
    endtask

    // Apply inputs right after an edge and wait to the middle of the cycle.
    task automatic step(input logic [7:0] v, input logic c, input logic a_, input logic b_,
                        input logic s_, input logic ac_, input logic e_, input logic ao_,
                        input logic f_);
        @(posedge clk);
        #1;
        drive(v, c, a_, b_, s_, ac_, e_, ao_, f_);
        @(negedge clk);
        #1;
    endtask

    initial begin
        drive(8'hFF, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_en = 1'b1;
        @(negedge clk);
        #1;
        // Reset with ai/FF still asserted.
        chk("rst_a", {24'd0, a_val}, 32'h0);
        chk("rst_b", {24'd0, b_val}, 32'h0);
        chk("rst_cf", {31'd0, carry_flag}, 32'h0);
        chk("rst_zf", {31'd0, zero_flag}, 32'h0);
        chk("rst_bus", {24'd0, bus_out}, 32'h0);
        chk("rst_oe", {31'd0, bus_oe}, 32'h0);

        //   data   clr ai bi su ac eo ao fi
        step(8'hFF, 0, 1, 0, 0, 0, 0, 0, 0);
        step(8'h01, 0, 0, 1, 0, 0, 0, 0, 0);
        step(8'h00, 0, 0, 0, 0, 0, 0, 0, 1);  // FF+01 -> CF=1
        step(8'h03, 0, 1, 0, 0, 0, 0, 0, 0);
        step(8'h04, 0, 0, 1, 0, 0, 0, 0, 0);
        step(8'h00, 0, 0, 0, 0, 1, 1, 0, 0);
        chk("adc_sum", {24'd0, bus_out}, 32'h08);
        step(8'h00, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("add_sum", {24'd0, bus_out}, 32'h07);

        step(8'h0D, 0, 1, 0, 0, 0, 0, 0, 0);
        step(8'h01, 0, 0, 1, 0, 0, 0, 0, 0);
        step(8'h00, 0, 0, 0, 1, 0, 1, 0, 1);
        chk("sub_sum", {24'd0, bus_out}, 32'h0C);
        step(8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sub_cf", {31'd0, carry_flag}, 32'h1);
        chk("sub_zf", {31'd0, zero_flag}, 32'h0);

        step(8'h01, 0, 1, 0, 0, 0, 0, 0, 0);
        step(8'h02, 0, 0, 1, 0, 0, 0, 0, 0);
        step(8'h00, 0, 0, 0, 1, 0, 1, 0, 1);
        chk("borrow_sum", {24'd0, bus_out}, 32'hFF);
        step(8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("borrow_cf", {31'd0, carry_flag}, 32'h0);
        chk("borrow_zf", {31'd0, zero_flag}, 32'h0);

        step(8'hFF, 0, 1, 0, 0, 0, 0, 0, 0);
        step(8'h01, 0, 0, 1, 0, 0, 0, 0, 0);
        step(8'h00, 0, 0, 0, 0, 0, 1, 0, 1);
        chk("wrap_sum", {24'd0, bus_out}, 32'h00);
        step(8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap_cf", {31'd0, carry_flag}, 32'h1);
        chk("wrap_zf", {31'd0, zero_flag}, 32'h1);

        // A=FF, B=03; fi with ai(00) must use FF+03 -> CF=1, ZF=0.
        step(8'h03, 0, 0, 1, 0, 0, 0, 0, 0);
        step(8'h00, 0, 1, 0, 0, 0, 0, 0, 1);
        step(8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("same_edge_cf", {31'd0, carry_flag}, 32'h1);
        chk("same_edge_zf", {31'd0, zero_flag}, 32'h0);
        chk("same_edge_a", {24'd0, a_val}, 32'h00);

        step(8'h00, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("conflict_bus", {24'd0, bus_out}, 32'h03);
        chk("conflict_flag", {31'd0, bus_conflict}, 32'h1);

        step(8'h07, 0, 1, 0, 0, 0, 0, 0, 0);
        step(8'h00, 1, 0, 0, 0, 0, 0, 0, 0);
        step(8'h00, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("midreset_bus", {24'd0, bus_out}, 32'h00);

        for (int i = 0; i < 3000; i++) begin
            step(8'($urandom_range(0, 255)),
                 ($urandom_range(0, 31) == 0),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));
        end

        @(posedge clk);
        #1;
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
